// File: rtl/hit_storage_writer.sv
// Sets single bits in a word-organised bit-array RAM, one bit per
// {word, letter} address from the upstream address generator.
// Addresses are buffered in a small FIFO. Each one is applied with a
// three-cycle read-modify-write. The array is swept to zero after reset
// or on clearRequest.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   address          {word index, bit index} from upstream
//   newAddress       address valid (accepted only if ready was seen)
//   clearRequest     pulse: flush FIFO, abandon RMW, re-clear array
//   storageReady     upstream may launch an address next cycle
//   memReadAddr      RAM read address (data returns one cycle later)
//   memReadData      RAM read data
//   memWriteEnable   RAM write strobe
//   memWriteAddr     RAM write address
//   memWriteData     RAM write data
//   clearing         high while the clear sweep runs
//   duplicateCount   saturating count of hits on already-set bits
//   overflow         sticky: an address was dropped on a full FIFO
module hit_storage_writer #(
   parameter int unsigned LETTERINDEXBITS = 4,
   parameter int unsigned WORDINDEXBITS   = 4,
   parameter int unsigned WORDLENGTH      = 2 ** LETTERINDEXBITS,
   parameter int unsigned MEMORYDEPTH     = 2 ** WORDINDEXBITS,
   parameter int unsigned FIFODEPTH       = 4,
   parameter int unsigned DUPCOUNTBITS    = 8
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic [LETTERINDEXBITS+WORDINDEXBITS-1:0] address,
   input  logic                                     newAddress,
   input  logic                                     clearRequest,
   output logic                                     storageReady,
   output logic [WORDINDEXBITS-1:0]                 memReadAddr,
   input  logic [WORDLENGTH-1:0]                    memReadData,
   output logic                                     memWriteEnable,
   output logic [WORDINDEXBITS-1:0]                 memWriteAddr,
   output logic [WORDLENGTH-1:0]                    memWriteData,
   output logic                                     clearing,
   output logic [DUPCOUNTBITS-1:0]                  duplicateCount,
   output logic                                     overflow
);

   localparam int unsigned ADDRW  = LETTERINDEXBITS + WORDINDEXBITS;
   localparam int unsigned PTRW   = $clog2(FIFODEPTH);
   localparam int unsigned CNTW   = PTRW + 1;
   localparam int unsigned SWEEPW = WORDINDEXBITS + 1;

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_READ  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   state_t                     state_q;
   logic [SWEEPW-1:0]          sweep_q;
   logic [ADDRW-1:0]           fifo_mem [FIFODEPTH];
   logic [PTRW-1:0]            wr_ptr_q;
   logic [PTRW-1:0]            rd_ptr_q;
   logic [CNTW-1:0]            count_q;
   logic [CNTW-1:0]            count_d;
   logic                       ready_q;
   logic [WORDINDEXBITS-1:0]   word_q;
   logic [LETTERINDEXBITS-1:0] bit_q;

   logic                       push_req;
   logic                       push_acc;
   logic                       push_drop;
   logic                       pop_en;
   logic                       stay_clear;
   logic [ADDRW-1:0]           head;

   // FIFO bookkeeping; clearRequest overrides every push and pop
   always_comb begin
      push_req   = 1'b0;
      push_acc   = 1'b0;
      push_drop  = 1'b0;
      pop_en     = 1'b0;
      stay_clear = 1'b0;
      count_d    = count_q;
      head       = fifo_mem[rd_ptr_q];

      // ready_q: upstream launched because it saw ready one cycle earlier
      push_req  = newAddress & ready_q & ~clearRequest;
      push_acc  = push_req & (count_q != CNTW'(FIFODEPTH));
      push_drop = push_req & (count_q == CNTW'(FIFODEPTH));
      pop_en    = (state_q == S_IDLE) & (count_q != '0) & ~clearRequest;

      if (clearRequest) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNTW'(push_acc) - CNTW'(pop_en);
      end

      // next state is CLEAR: new request, or sweep not yet finished
      stay_clear = clearRequest |
                   ((state_q == S_CLEAR) & (sweep_q != SWEEPW'(MEMORYDEPTH)));
   end

   // FIFO storage needs no reset; occupancy is tracked by count_q
   always_ff @(posedge clock) begin
      if (push_acc) begin
         fifo_mem[wr_ptr_q] <= address;
      end
   end

   // Control FSM, FIFO pointers and all registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_CLEAR;
         sweep_q        <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         ready_q        <= 1'b0;
         word_q         <= '0;
         bit_q          <= '0;
         storageReady   <= 1'b0;
         memReadAddr    <= '0;
         memWriteEnable <= 1'b0;
         memWriteAddr   <= '0;
         memWriteData   <= '0;
         clearing       <= 1'b1;
         duplicateCount <= '0;
         overflow       <= 1'b0;
      end else begin
         ready_q      <= storageReady;
         count_q      <= count_d;
         // one slot of slack absorbs the address already in flight
         storageReady <= ~stay_clear & (count_d <= CNTW'(FIFODEPTH - 2));

         if (push_drop) begin
            overflow <= 1'b1;
         end

         if (clearRequest) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_acc) begin
               wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (pop_en) begin
               rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
         end

         if (clearRequest) begin
            // abandon any RMW in progress without writing
            state_q        <= S_CLEAR;
            sweep_q        <= '0;
            memWriteEnable <= 1'b0;
            clearing       <= 1'b1;
         end else begin
            case (state_q)
               S_CLEAR: begin
                  if (sweep_q == SWEEPW'(MEMORYDEPTH)) begin
                     // last zero write was issued on the previous edge
                     state_q        <= S_IDLE;
                     memWriteEnable <= 1'b0;
                     clearing       <= 1'b0;
                  end else begin
                     memWriteEnable <= 1'b1;
                     memWriteAddr   <= sweep_q[WORDINDEXBITS-1:0];
                     memWriteData   <= '0;
                     sweep_q        <= sweep_q + SWEEPW'(1);
                  end
               end
               S_IDLE: begin
                  memWriteEnable <= 1'b0;
                  if (pop_en) begin
                     memReadAddr <= head[ADDRW-1 -: WORDINDEXBITS];
                     word_q      <= head[ADDRW-1 -: WORDINDEXBITS];
                     bit_q       <= head[LETTERINDEXBITS-1:0];
                     state_q     <= S_READ;
                  end
               end
               S_READ: begin
                  memWriteEnable <= 1'b0;
                  state_q        <= S_WRITE;
               end
               S_WRITE: begin
                  memWriteEnable <= 1'b1;
                  memWriteAddr   <= word_q;
                  memWriteData   <= memReadData | (WORDLENGTH'(1) << bit_q);
                  if (memReadData[bit_q] && (duplicateCount != '1)) begin
                     duplicateCount <= duplicateCount + DUPCOUNTBITS'(1);
                  end
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_CLEAR;
                  sweep_q <= '0;
               end
            endcase
         end
      end
   end

endmodule
